// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS multiply/divide unit.
//   DEFAULT_WIDTH       default operand/result width
//   MDU_*               op encodings carried on the 2-bit op port
//   mdu_state_t         FSM state encoding (IDLE -> CALC -> FIX -> IDLE)
//   op_is_div/op_is_signed  decode helpers for the op field
package mips_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic [1:0] MDU_MULT  = 2'b00;
    localparam logic [1:0] MDU_MULTU = 2'b01;
    localparam logic [1:0] MDU_DIV   = 2'b10;
    localparam logic [1:0] MDU_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } mdu_state_t;

    function automatic logic op_is_div(input logic [1:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == MDU_MULT) || (op == MDU_DIV);
    endfunction

endpackage

// File: rtl/mdu_iter_step.sv
// One combinational iteration of the multiply/divide datapath.
//   acc       in   2*WIDTH  accumulator: multiply {partial product hi, remaining multiplier}
//                           divide {partial remainder, remaining dividend bits}
//   operand   in   WIDTH    multiplicand magnitude / divisor magnitude
//   div_mode  in   1        0 = shift-add multiply step, 1 = restoring shift-subtract step
//   acc_next  out  2*WIDTH  accumulator after this step (divide: LSB left 0 for the quotient bit)
//   q_bit     out  1        quotient bit produced by a divide step (0 in multiply mode)
module mdu_iter_step
    import mips_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   operand,
    input  logic               div_mode,
    output logic [2*WIDTH-1:0] acc_next,
    output logic               q_bit
);

    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   rem_shift_s;
    logic [WIDTH-1:0] diff_s;

    // Single iteration: add-then-shift-right for multiply, shift-left-then-trial-subtract for divide.
    always_comb begin
        // Carry out of the add becomes the top bit after the right shift.
        sum_s       = {1'b0, acc[2*WIDTH-1:WIDTH]}
                    + (acc[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
        // Partial remainder with the next dividend bit shifted in; can briefly need WIDTH+1 bits.
        rem_shift_s = acc[2*WIDTH-1:WIDTH-1];
        // The true difference is below the divisor whenever it is used, so WIDTH bits suffice.
        diff_s      = rem_shift_s[WIDTH-1:0] - operand;
        if (div_mode) begin
            if (rem_shift_s >= {1'b0, operand}) begin
                acc_next = {diff_s, acc[WIDTH-2:0], 1'b0};
                q_bit    = 1'b1;
            end else begin
                acc_next = {rem_shift_s[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
                q_bit    = 1'b0;
            end
        end else begin
            acc_next = {sum_s, acc[WIDTH-1:1]};
            q_bit    = 1'b0;
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit with HI/LO registers.
//   clk, reset        clock and synchronous active-high reset
//   start, op         begin MULT/MULTU/DIV/DIVU (accepted only when idle)
//   srcA, srcB        multiplicand/dividend and multiplier/divisor
//   hi_we, lo_we      MTHI/MTLO write enables (idle, no start), data on wdata
//   busy              operation in flight (pipeline stall)
//   done              one-cycle pulse when HI/LO have just been written by an operation
//   hi, lo            HI (product high / remainder) and LO (product low / quotient)
// Operands are reduced to magnitudes on entry; WIDTH unsigned iterations run in CALC,
// and FIX restores signs before writing HI/LO.
module mult_div_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    mdu_state_t         state_r;
    logic [CNT_W-1:0]   counter_r;
    logic [2*WIDTH-1:0] acc_r;
    logic [WIDTH-1:0]   operand_r;
    logic               is_div_r;
    logic               neg_res_r;   // product / quotient needs negating
    logic               neg_rem_r;   // remainder takes the dividend's sign
    logic               dbz_r;       // divisor was zero

    logic               sign_a_s;
    logic               sign_b_s;
    logic [WIDTH-1:0]   mag_a_s;
    logic [WIDTH-1:0]   mag_b_s;
    logic [2*WIDTH-1:0] init_acc_s;
    logic [WIDTH-1:0]   init_opnd_s;
    logic [2*WIDTH-1:0] step_acc_s;
    logic               step_q_s;
    logic [2*WIDTH-1:0] acc_calc_s;
    logic [2*WIDTH-1:0] prod_neg_s;
    logic [WIDTH-1:0]   fix_hi_s;
    logic [WIDTH-1:0]   fix_lo_s;

    mdu_iter_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .acc      (acc_r),
        .operand  (operand_r),
        .div_mode (is_div_r),
        .acc_next (step_acc_s),
        .q_bit    (step_q_s)
    );

    // Operand entry: magnitudes, sign flags and the initial accumulator layout.
    always_comb begin
        sign_a_s = op_is_signed(op) & srcA[WIDTH-1];
        sign_b_s = op_is_signed(op) & srcB[WIDTH-1];
        if (sign_a_s) begin
            mag_a_s = -srcA;
        end else begin
            mag_a_s = srcA;
        end
        if (sign_b_s) begin
            mag_b_s = -srcB;
        end else begin
            mag_b_s = srcB;
        end
        // Multiply keeps the multiplier in the low half; divide keeps the dividend there.
        if (op_is_div(op)) begin
            init_acc_s  = {{WIDTH{1'b0}}, mag_a_s};
            init_opnd_s = mag_b_s;
        end else begin
            init_acc_s  = {{WIDTH{1'b0}}, mag_b_s};
            init_opnd_s = mag_a_s;
        end
    end

    // Next accumulator in CALC: divide steps shift the fresh quotient bit into the LSB.
    always_comb begin
        if (is_div_r) begin
            acc_calc_s = {step_acc_s[2*WIDTH-1:1], step_q_s};
        end else begin
            acc_calc_s = step_acc_s;
        end
    end

    // Sign correction of the finished magnitude result.
    always_comb begin
        prod_neg_s = -acc_r;
        if (is_div_r) begin
            // Divide by zero leaves an all-ones quotient regardless of signs.
            if (dbz_r) begin
                fix_lo_s = {WIDTH{1'b1}};
            end else if (neg_res_r) begin
                fix_lo_s = -acc_r[WIDTH-1:0];
            end else begin
                fix_lo_s = acc_r[WIDTH-1:0];
            end
            if (neg_rem_r) begin
                fix_hi_s = -acc_r[2*WIDTH-1:WIDTH];
            end else begin
                fix_hi_s = acc_r[2*WIDTH-1:WIDTH];
            end
        end else begin
            if (neg_res_r) begin
                fix_hi_s = prod_neg_s[2*WIDTH-1:WIDTH];
                fix_lo_s = prod_neg_s[WIDTH-1:0];
            end else begin
                fix_hi_s = acc_r[2*WIDTH-1:WIDTH];
                fix_lo_s = acc_r[WIDTH-1:0];
            end
        end
    end

    // Control FSM, iteration datapath registers and the HI/LO architectural registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            counter_r <= {CNT_W{1'b0}};
            acc_r     <= {(2*WIDTH){1'b0}};
            operand_r <= {WIDTH{1'b0}};
            is_div_r  <= 1'b0;
            neg_res_r <= 1'b0;
            neg_rem_r <= 1'b0;
            dbz_r     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            hi        <= {WIDTH{1'b0}};
            lo        <= {WIDTH{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        // Start takes priority; any simultaneous MTHI/MTLO is dropped.
                        acc_r     <= init_acc_s;
                        operand_r <= init_opnd_s;
                        is_div_r  <= op_is_div(op);
                        neg_res_r <= sign_a_s ^ sign_b_s;
                        neg_rem_r <= sign_a_s;
                        dbz_r     <= (srcB == {WIDTH{1'b0}});
                        counter_r <= CNT_W'(WIDTH);
                        busy      <= 1'b1;
                        state_r   <= CALC;
                    end else begin
                        if (hi_we) begin
                            hi <= wdata;
                        end
                        if (lo_we) begin
                            lo <= wdata;
                        end
                    end
                end
                CALC: begin
                    acc_r     <= acc_calc_s;
                    counter_r <= counter_r - CNT_W'(1);
                    if (counter_r == CNT_W'(1)) begin
                        state_r <= FIX;
                    end
                end
                FIX: begin
                    hi      <= fix_hi_s;
                    lo      <= fix_lo_s;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [1:0]    op;
    logic [W-1:0]  srcA;
    logic [W-1:0]  srcB;
    logic          hi_we;
    logic          lo_we;
    logic [W-1:0]  wdata;
    logic          busy;
    logic          done;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           at;
    } exp_t;

    exp_t sb_q[$];

    mult_div_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .srcA  (srcA),
        .srcB  (srcB),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Reference model: plain 64-bit / integer arithmetic on the architectural rules.
    function automatic void model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] h, output logic [W-1:0] l);
        logic [63:0] p;
        int sa;
        int sb;
        sa = $signed(a);
        sb = $signed(b);
        h  = 32'd0;
        l  = 32'd0;
        case (o)
            2'b00: begin
                p = 64'(longint'(sa) * longint'(sb));
                h = p[63:32];
                l = p[31:0];
            end
            2'b01: begin
                p = {32'd0, a} * {32'd0, b};
                h = p[63:32];
                l = p[31:0];
            end
            2'b10: begin
                if (b == 32'd0) begin
                    h = a;
                    l = 32'hFFFFFFFF;
                end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
                    h = 32'd0;
                    l = 32'h80000000;
                end else begin
                    l = 32'(sa / sb);
                    h = 32'(sa % sb);
                end
            end
            default: begin
                if (b == 32'd0) begin
                    h = a;
                    l = 32'hFFFFFFFF;
                end else begin
                    l = a / b;
                    h = a % b;
                end
            end
        endcase
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (done === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: done=1 at cycle %0d with nothing outstanding", cyc);
            end else begin
                e = sb_q.pop_front();
                chk("result_hi", hi, e.hi);
                chk("result_lo", lo, e.lo);
                chk("done_cycle", 32'(cyc), 32'(e.at));
            end
        end
    end

    // Issue one operation, push its expectation, and follow busy until it drops.
    task automatic run_op(input string name, input logic [1:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] eh, input logic [W-1:0] el,
                          input bit interfere, input bit with_lo_we);
        exp_t e;
        int n;
        bit changed;
        logic [W-1:0] h0;
        logic [W-1:0] l0;
        @(negedge clk);
        start = 1'b1;
        op    = o;
        srcA  = a;
        srcB  = b;
        lo_we = with_lo_we;
        wdata = 32'hDEADBEEF;
        e.hi  = eh;
        e.lo  = el;
        e.at  = cyc + 1 + W + 1;
        sb_q.push_back(e);
        h0 = hi;
        l0 = lo;
        @(negedge clk);
        start = 1'b0;
        lo_we = 1'b0;
        op    = 2'($urandom);
        srcA  = $urandom;
        srcB  = $urandom;
        n = 0;
        changed = 1'b0;
        while (busy === 1'b1 && n < 100) begin
            if (hi !== h0 || lo !== l0) changed = 1'b1;
            if (interfere && n == 5) begin
                start = 1'b1;
                hi_we = 1'b1;
                wdata = 32'hCAFEF00D;
                op    = 2'b11;
                srcA  = 32'd9;
                srcB  = 32'd3;
            end else begin
                start = 1'b0;
                hi_we = 1'b0;
            end
            n++;
            @(negedge clk);
        end
        start = 1'b0;
        hi_we = 1'b0;
        chk({name, "_busy_cycles"}, 32'(n), 32'd33);
        chk({name, "_hold_while_busy"}, 32'(changed), 32'd0);
    endtask

    initial begin
        logic [W-1:0] eh;
        logic [W-1:0] el;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [1:0]   o;
        logic [W-1:0] l0;
        int           n;

        reset = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        srcA  = 32'd0;
        srcB  = 32'd0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        wdata = 32'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);

        // Directed cases with hand-derived results.
        run_op("multu_ffff_x2", 2'b01, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE, 1'b0, 1'b0);
        run_op("mult_m3_x7", 2'b00, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 1'b0);
        run_op("div_m7_by2", 2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0);
        run_op("divu_100_by7", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b0);
        run_op("divu_by_zero", 2'b11, 32'h64, 32'd0, 32'h64, 32'hFFFFFFFF, 1'b0, 1'b0);
        run_op("div_neg_by_zero", 2'b10, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b0, 1'b0);
        run_op("div_overflow", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b0, 1'b0);
        run_op("div_m100_by_m7", 2'b10, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd14, 1'b0, 1'b0);

        // Start and MTHI while busy must be ignored.
        model(2'b01, 32'h12345678, 32'h9ABCDEF0, eh, el);
        run_op("multu_interfered", 2'b01, 32'h12345678, 32'h9ABCDEF0, eh, el, 1'b1, 1'b0);

        // Reset in the middle of a divide discards it.
        @(negedge clk);
        start = 1'b1;
        op    = 2'b10;
        srcA  = 32'd1000;
        srcB  = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midop_reset_busy", 32'(busy), 32'd0);
        chk("midop_reset_hi", hi, 32'd0);
        chk("midop_reset_lo", lo, 32'd0);
        repeat (40) @(negedge clk);
        chk("midop_reset_still_idle", 32'(busy), 32'd0);

        // MTHI alone, then MTHI+MTLO together.
        run_op("divu_seed", 2'b11, 32'd77, 32'd5, 32'd2, 32'd15, 1'b0, 1'b0);
        l0 = lo;
        hi_we = 1'b1;
        wdata = 32'h1234;
        @(negedge clk);
        hi_we = 1'b0;
        chk("mthi_hi", hi, 32'h1234);
        chk("mthi_lo_unchanged", lo, l0);
        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = 32'hA5A5A5A5;
        @(negedge clk);
        hi_we = 1'b0;
        lo_we = 1'b0;
        chk("mthi_mtlo_hi", hi, 32'hA5A5A5A5);
        chk("mthi_mtlo_lo", lo, 32'hA5A5A5A5);

        // Start together with MTLO: the operation wins.
        run_op("start_with_mtlo", 2'b01, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 1'b1);

        // Randomized operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: a = 32'h80000000;
                3: b = 32'hFFFFFFFF;
                default: ;
            endcase
            model(o, a, b, eh, el);
            run_op("random_op", o, a, b, eh, el, 1'b0, 1'b0);
        end

        n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
